// File: rtl/gray_burst_arbiter_if.sv
// Bus bundle between the requesting clients (master side) and gray_burst_arbiter (slave side).
interface gray_burst_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int CBITS = 18,
  parameter int LBITS = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*LBITS-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [CBITS-1:0]      gray_c;
  logic                  wrap;
  logic                  busy;

  modport master (output req, len, input gnt, done, gray_c, wrap, busy);
  modport slave  (input req, len, output gnt, done, gray_c, wrap, busy);
endinterface

// File: rtl/gray_burst_arbiter.sv
// Round-robin burst arbiter sharing one binary counter with a registered Gray-code output.
// Define GRAY_ARB_FIXED_PRIO_EN to switch arbitration to fixed lowest-index priority.
module gray_burst_arbiter #(
  parameter int NREQ  = 4,
  parameter int CBITS = 18,
  parameter int LBITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_burst_arbiter_if.slave  bus
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef GRAY_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CBITS-1:0]  cnt_q, cnt_d;
  logic [CBITS-1:0]  gray_q, gray_d;
  logic [LBITS-1:0]  rem_q, rem_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [PTRW-1:0]   win_q, win_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              wrap_q, wrap_d;

  logic [LBITS-1:0]  len_arr [NREQ];
  logic [PTRW-1:0]   arb_base;
  logic [PTRW-1:0]   arb_sel;
  logic              arb_found;
  int                arb_idx;
  logic [LBITS-1:0]  arb_len;
  logic [NREQ-1:0]   arb_onehot;
  logic [NREQ-1:0]   win_onehot;
  logic [PTRW-1:0]   next_ptr;
  logic              win_req;
  logic              last_step;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      len_arr[i] = bus.len[i*LBITS +: LBITS];
    end
  end

  // Scanning from the highest offset down leaves the first set bit at or above the base as winner.
  always_comb begin
    arb_base  = FIXED_PRIO ? '0 : ptr_q;
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_idx   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      arb_idx = (int'(arb_base) + i) % NREQ;
      if (bus.req[PTRW'(arb_idx)]) begin
        arb_found = 1'b1;
        arb_sel   = PTRW'(arb_idx);
      end
    end
  end

  assign arb_len    = len_arr[arb_sel];
  assign arb_onehot = ONE_HOT0 << arb_sel;
  assign win_onehot = ONE_HOT0 << win_q;
  assign win_req    = bus.req[win_q];
  assign last_step  = (rem_q == LBITS'(1));
  assign next_ptr   = (win_q == PTRW'(NREQ - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gray_q  <= '0;
      rem_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gray_q  <= gray_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = (arb_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!win_req || last_step) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gray is derived from the next count so the registered code never lags the count.
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    ptr_d  = ptr_q;
    win_d  = win_q;
    gnt_d  = '0;
    done_d = '0;
    wrap_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          win_d = arb_sel;
          rem_d = arb_len;
          if (arb_len != '0) begin
            gnt_d = arb_onehot;
          end else begin
            done_d = arb_onehot;
          end
        end
      end
      RUN: begin
        if (win_req) begin
          cnt_d  = cnt_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          wrap_d = &cnt_q;
          if (last_step) begin
            done_d = win_onehot;
          end else begin
            gnt_d = gnt_q;
          end
        end else begin
          done_d = win_onehot;
        end
      end
      DONE: begin
        ptr_d = FIXED_PRIO ? '0 : next_ptr;
      end
      default: begin
      end
    endcase
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.gray_c = gray_q;
  assign bus.wrap   = wrap_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: doc/gray_burst_arbiter.md
# gray_burst_arbiter

Round-robin arbiter and sequencer that shares one Gray-code counter between several requesters. Each granted requester advances the counter by a burst of increments of its chosen length. The block owns the binary count and its registered Gray encoding, and flags every wrap. It sits between client blocks that need monotonic Gray-coded stamps and the single shared counter.

## Interface

Parameters:
- NREQ, 4 — number of requesters (≥2).
- CBITS, 18 — counter / Gray output width.
- LBITS, 8 — burst-length field width per requester.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level.
- len  input  NREQ*LBITS  burst length; requester i uses bits [i*LBITS +: LBITS]. Sampled only at grant.
- gnt  output  NREQ  one-hot grant, registered; high for the whole RUN phase of the winner.
- done  output  NREQ  one-hot, one-cycle completion pulse, registered.
- gray_c  output  CBITS  registered Gray code of internal count, always equal to cnt ^ (cnt >> 1).
- wrap  output  1  one-cycle pulse on the edge where the count goes from all-ones to 0.
- busy  output  1  high whenever state is not IDLE.

## Operation

- Internal state:
  - cnt[CBITS-1:0] binary count.
  - rem[LBITS-1:0] remaining increments.
  - ptr, the round-robin pointer.
  - win, the winner index.
  - FSM in IDLE, RUN, or DONE.
- Reset (rst low, asynchronous):
  - All outputs go to 0 immediately: gnt=0, done=0, gray_c=0, wrap=0, busy=0.
  - cnt=0, rem=0, ptr=0, state=IDLE.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the winner: the first set req bit searching from ptr upward, modulo NREQ.
  - Load rem = len[win] and set win.
  - If len[win] ≠ 0: gnt[win]=1, go to RUN.
  - If len[win] = 0: gnt stays 0, done[win]=1, go to DONE.
- RUN:
  - If req[win] is still high:
    - Update cnt=cnt+1 (mod 2^CBITS), gray_c=gray(cnt+1), rem=rem−1.
    - If rem was 1: gnt=0, done[win]=1, go to DONE.
  - If req[win] dropped (abort):
    - No increment on this edge.
    - gnt=0, done[win]=1, go to DONE.
- DONE:
  - done is cleared on the next edge.
  - Advance ptr = (win+1) mod NREQ.
  - Go to IDLE.
  - No arbitration happens in DONE.
- wrap: set on any increment edge where cnt was all-ones, cleared on the next edge.
- Requests from non-winners during RUN/DONE are ignored. They are not latched; the level is re-sampled in IDLE.
- The counter never moves outside RUN.

## Timing

- Request latency: req sampled at IDLE edge k → gnt high after edge k.
- Burst of length L ≥ 1:
  - Increments occur on edges k+1 … k+L.
  - gnt falls and done rises at edge k+L.
  - done falls at edge k+L+1 (state returns to IDLE).
  - Earliest next grant is at edge k+L+2.
- Length 0: done high after edge k, IDLE again after edge k+1, counter unchanged.
- gray_c changes on the same edge as cnt; zero lag.
- Fairness: a continuously asserted req is granted within NREQ grant cycles.
- Reset mid-burst: the burst is lost, done is not pulsed, and the count restarts from 0.

## Configuration

- GRAY_ARB_FIXED_PRIO_EN
  - Defined: fixed priority. The lowest-index asserted req always wins, and ptr is held at 0 and not advanced.
  - Undefined (default): round-robin as described above.
  - Everything else is identical either way.

## Test plan

- Reset: rst low with req=4'b1111 → gnt=0, done=0, gray_c=0, wrap=0, busy=0 while low and on the first edge after release with req=0.
- Single burst: req=4'b0100, len[2]=5 → gnt=4'b0100 for 5 cycles, gray_c sequence 1,3,2,6,7, then done=4'b0100 for 1 cycle, busy falls afterwards.
- Round-robin: req=4'b1111, all len=1 → grant order 0,1,2,3,0. Under GRAY_ARB_FIXED_PRIO_EN the order is 0,0,0,0.
- Abort: req[1] grants len=10, req[1] drops after 3 increments → gray_c frozen at gray(3)=2, done[1] pulses, no further increments.
- Wrap: with CBITS=4, drive 16 total increments from reset → wrap pulses exactly once, on the edge where gray_c goes 4'b1000 → 4'b0000.
- Zero length plus mid-burst reset: len[3]=0 → done[3] pulse with no gnt and unchanged gray_c. Then a len=8 burst with rst pulsed low at increment 4 → all outputs 0 at once, no done pulse.
